// File: rtl/apb_slave_regbank.sv
`timescale 1ns/1ps
// APB4 completer: word-addressed register bank with byte-strobe writes,
// fixed wait states, address/alignment/protection error reporting.
// PRDATA/PREADY/PSLVERR are registered and held at zero outside the
// single completion cycle.
module apb_slave_regbank #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter int                    SECURE_ONLY = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int AL = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * NB);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

   typedef enum logic [1:0] {
      st_idle,
      st_access,
      st_done
   } state_t;

   state_t                state_reg, state_next;
   logic [3:0]            count_reg, count_next;

   // transfer attributes captured at the setup edge
   logic [IW-1:0]         idx_reg;
   logic                  write_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [NB-1:0]         strb_reg;
   logic                  err_reg;

   logic [DATA_WIDTH-1:0] prdata_reg;
   logic                  pready_reg;
   logic                  pslverr_reg;

   logic                  setup_fire;
   logic                  done_enter;
   logic                  commit;

   logic [ADDR_WIDTH-1:0] offset;
   logic                  err_now;
   logic [IW-1:0]         idx_now;
   logic                  err_sel;
   logic [IW-1:0]         idx_sel;
   logic                  write_sel;
   logic [DATA_WIDTH-1:0] rd_word;

   // PPROT[0] (privileged) and PPROT[2] (instruction) carry no meaning here
   logic                  unused_prot;
   assign unused_prot = PPROT[2] ^ PPROT[0];

   // Decode of the live bus: a below-base address wraps the offset to a huge
   // value, so a single unsigned compare covers both ends of the window.
   assign offset  = PADDR - BASE_ADDR;
   assign err_now = !({1'b0, offset} < SPAN)
                    || ((PADDR & ALIGN_MASK) != '0)
                    || ((SECURE_ONLY != 0) && PPROT[1]);
   assign idx_now = offset[AL +: IW];

   // With zero wait states completion is decided on the setup edge itself,
   // before the latched copies exist, so the live decode is used there.
   assign err_sel   = (state_reg == st_idle) ? err_now : err_reg;
   assign idx_sel   = (state_reg == st_idle) ? idx_now : idx_reg;
   assign write_sel = (state_reg == st_idle) ? PWRITE  : write_reg;

   // State and wait counter register
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_reg <= st_idle;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // Next-state logic: setup, wait countdown, completion, abort on PSEL drop
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      setup_fire = 1'b0;
      done_enter = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         st_idle: begin
            if (PSEL && !PENABLE) begin
               setup_fire = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_next = st_done;
                  done_enter = 1'b1;
               end else begin
                  state_next = st_access;
                  count_next = 4'(WAIT_STATES);
               end
            end
         end
         st_access: begin
            if (!PSEL) begin
               state_next = st_idle;
               count_next = '0;
            end else if (PENABLE) begin
               if (count_reg <= 4'd1) begin
                  state_next = st_done;
                  count_next = '0;
                  done_enter = 1'b1;
               end else begin
                  count_next = count_reg - 4'd1;
               end
            end
         end
         st_done: begin
            state_next = st_idle;
            // write lands on the edge that ends the PREADY cycle, only if
            // the requester is still selecting us
            commit     = PSEL && write_reg && !err_reg;
         end
         default: begin
            state_next = st_idle;
            count_next = '0;
         end
      endcase
   end

   // Setup capture and registered response outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         idx_reg     <= '0;
         write_reg   <= 1'b0;
         wdata_reg   <= '0;
         strb_reg    <= '0;
         err_reg     <= 1'b0;
         prdata_reg  <= '0;
         pready_reg  <= 1'b0;
         pslverr_reg <= 1'b0;
      end else begin
         if (setup_fire) begin
            idx_reg   <= idx_now;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            strb_reg  <= PSTRB;
            err_reg   <= err_now;
         end
         pready_reg  <= done_enter;
         pslverr_reg <= done_enter && err_sel;
         prdata_reg  <= (done_enter && !err_sel && !write_sel) ? rd_word : '0;
      end
   end

   // One storage array per byte lane so each lane has a single writer
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         // Lane write on commit when its strobe was set; reset clears all words
         always_ff @(posedge PCLK) begin
            if (PRESET) begin
               for (int i = 0; i < DEPTH; i++) begin
                  lane_mem[i] <= '0;
               end
            end else if (commit && strb_reg[gi]) begin
               lane_mem[idx_reg] <= wdata_reg[gi*8 +: 8];
            end
         end

         assign rd_word[gi*8 +: 8] = lane_mem[idx_sel];
      end
   endgenerate

   assign PRDATA  = prdata_reg;
   assign PREADY  = pready_reg;
   assign PSLVERR = pslverr_reg;

endmodule
